// File: rtl/mac_pkg.sv
// Shared constants and types for the 4-bit multiply-accumulate datapath.
package mac_pkg;

  localparam int MAC_N     = 4;
  localparam int MAC_ACC_W = 8;

  typedef logic [MAC_N-1:0]     operand_t;
  typedef logic [MAC_ACC_W-1:0] acc_t;

endpackage : mac_pkg

// File: rtl/mac4_mult.sv
// Combinational unsigned N x N -> 2N shift-and-add multiplier.
module mac4_mult #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] prod
);

  logic [2*N-1:0] a_ext;

  assign a_ext = {{N{1'b0}}, a};

  // Sum one shifted copy of the multiplicand for every set multiplier bit.
  always_comb begin
    prod = '0;
    for (int i = 0; i < N; i++) begin
      if (b[i]) begin
        prod = prod + (a_ext << i);
      end
    end
  end

endmodule : mac4_mult

// File: rtl/mac4_unit.sv
// Unsigned multiply-accumulate: accumulator += A*B every clock, wrapping
// modulo 2^ACC_W. The only way to restart the sum is reset_n.
module mac4_unit
  import mac_pkg::*;
#(
  parameter int N     = MAC_N,
  parameter int ACC_W = 2 * N
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  output logic [ACC_W-1:0] accumulator
);

  logic [2*N-1:0]   prod;
  logic [ACC_W-1:0] accumulator_d;
  logic [ACC_W-1:0] accumulator_q;

  mac4_mult #(
    .N (N)
  ) u_mult (
    .a    (A),
    .b    (B),
    .prod (prod)
  );

  // Next sum; the cast resizes the product so the add wraps at ACC_W bits.
  always_comb begin
    accumulator_d = accumulator_q + ACC_W'(prod);
  end

  // Accumulator register, cleared immediately when reset_n drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accumulator_q <= '0;
    end else begin
      accumulator_q <= accumulator_d;
    end
  end

  assign accumulator = accumulator_q;

endmodule : mac4_unit

// File: tb/tb_mac4_unit.sv
// Self-checking bench for mac4_unit: directed vector table, reset corner
// sequences and a randomized run against an independent modulo-256 model.
module tb_mac4_unit;
  import mac_pkg::*;

  typedef struct {
    bit       rst_before;
    operand_t a;
    operand_t b;
    acc_t     exp;
  } vec_t;

  logic     clk = 1'b0;
  logic     reset_n = 1'b1;
  operand_t A = '0;
  operand_t B = '0;
  acc_t     accumulator;

  int errors = 0;
  int checks = 0;
  int model  = 0;
  acc_t exp_q[$];

  mac4_unit #(
    .N     (MAC_N),
    .ACC_W (MAC_ACC_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .A           (A),
    .B           (B),
    .accumulator (accumulator)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input acc_t act, input acc_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: accumulator=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Assert reset between edges with nonzero operands applied; the clear must
  // be immediate and the following edge must be ignored.
  task automatic rst_pulse(input string name);
    @(negedge clk);
    reset_n = 1'b0;
    A = 4'd15;
    B = 4'd15;
    #1;
    check({name, "_async_clear"}, accumulator, 8'd0);
    @(posedge clk);
    #1;
    check({name, "_hold"}, accumulator, 8'd0);
    model = 0;
  endtask

  // Drive one operand pair (releasing reset if held), queue the expectation,
  // and compare once the edge has produced the result.
  task automatic step(input string name, input operand_t a, input operand_t b, input acc_t exp);
    acc_t e;
    @(negedge clk);
    reset_n = 1'b1;
    A = a;
    B = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, accumulator, e);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    int   a_r, b_r;

    vecs.push_back('{1'b0, 4'd2,  4'd3,  8'd6});
    vecs.push_back('{1'b1, 4'd13, 4'd4,  8'd52});
    vecs.push_back('{1'b0, 4'd7,  4'd3,  8'd73});
    vecs.push_back('{1'b0, 4'd3,  4'd6,  8'd91});
    vecs.push_back('{1'b1, 4'd10, 4'd5,  8'd50});
    vecs.push_back('{1'b1, 4'd15, 4'd15, 8'd225});
    vecs.push_back('{1'b0, 4'd15, 4'd15, 8'd194});
    vecs.push_back('{1'b0, 4'd0,  4'd9,  8'd194});
    vecs.push_back('{1'b0, 4'd9,  4'd0,  8'd194});

    // Reset held across two edges, then idle accumulation of zeros.
    #1;
    reset_n = 1'b0;
    A = 4'd5;
    B = 4'd7;
    #1;
    check("por_clear", accumulator, 8'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("por_hold", accumulator, 8'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step("idle_zero", 4'd0, 4'd0, 8'd0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) begin
        rst_pulse($sformatf("vec%0d_rst", i));
      end
      step($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Randomized run with occasional reset pulses against the reference model.
    rst_pulse("rand_start");
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        rst_pulse("rand_rst");
      end
      a_r = int'($urandom_range(0, 15));
      b_r = int'($urandom_range(0, 15));
      model = (model + a_r * b_r) % 256;
      step("rand", operand_t'(a_r), operand_t'(b_r), acc_t'(model));
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mac4_unit
